led_pwm_duty_decoder: RTL and testbench

Single-channel PWM duty-cycle decoder: the receive-side inverse of the LED PWM driver. It samples an external PWM line, measures period and high time in i_clk cycles, and converts the ratio to an 8-bit palette value (0..255). It is used for loopback self-test of LED PWM outputs and for reading external PWM sources into the same 8-bit palette domain.

---
 rtl/led_pwm_duty_decoder.sv | 101 ++++++++++
 tb/tb_led_pwm_duty_decoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/led_pwm_duty_decoder.sv
// led_pwm_duty_decoder: measures period/high time of an external PWM line and
// decodes the duty ratio into an 8-bit rounded palette value.
module led_pwm_duty_decoder #(
  parameter int parm_FCLK                    = 40_000_000,
  parameter int parm_pwm_period_milliseconds = 10,
  parameter int parm_timeout_periods         = 2,
  parameter int parm_min_period_cycles       = 16
) (
  input  logic        i_clk,
  input  logic        i_srst,
  input  logic        ei_pwm,
  output logic [7:0]  o_duty_value,
  output logic        o_duty_valid,
  output logic [31:0] o_period_cycles,
  output logic        o_signal_lost
);
  localparam int          c_pwm_period_ms  = parm_FCLK / 1000 * parm_pwm_period_milliseconds;
  localparam logic [31:0] c_timeout_cycles = 32'(c_pwm_period_ms * parm_timeout_periods);
  localparam logic [31:0] c_min_period     = 32'(parm_min_period_cycles);
  typedef enum logic [1:0] {ST_WAIT_RISE, ST_MEASURE, ST_DIVIDE, ST_OUTPUT} state_t;
  state_t      r_state;
  logic        r_s1, r_sync, r_prev;
  logic [31:0] r_period_cnt, r_high_cnt, r_p, r_h;
  logic [39:0] r_rem;
  logic [8:0]  r_q;
  logic [3:0]  r_bit;
  logic        w_rise, w_timeout, w_ge;
  logic [39:0] w_num, w_div;
  logic [8:0]  w_q;
  assign w_rise    = r_sync & ~r_prev;
  // One-shot: once lost is flagged the saturated counter must not re-trigger.
  assign w_timeout = !w_rise && !o_signal_lost && (r_period_cnt == c_timeout_cycles);
  assign w_num     = {8'd0, r_h} * 40'd255 + {9'd0, r_p[31:1]};
  assign w_div     = {8'd0, r_p} << r_bit;
  assign w_ge      = r_rem >= w_div;
  assign w_q       = r_q | {8'd0, w_ge};
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_s1            <= 1'b0;
      r_sync          <= 1'b0;
      r_prev          <= 1'b0;
      r_period_cnt    <= '0;
      r_high_cnt      <= '0;
      r_p             <= '0;
      r_h             <= '0;
      r_rem           <= '0;
      r_q             <= '0;
      r_bit           <= '0;
      r_state         <= ST_WAIT_RISE;
      o_duty_value    <= '0;
      o_duty_valid    <= 1'b0;
      o_period_cycles <= '0;
      o_signal_lost   <= 1'b0;
    end else begin
      r_s1         <= ei_pwm;
      r_sync       <= r_s1;
      r_prev       <= r_sync;
      r_period_cnt <= w_rise ? 32'd1 : (r_period_cnt == c_timeout_cycles ? r_period_cnt : r_period_cnt + 32'd1);
      r_high_cnt   <= w_rise ? 32'd1 : r_high_cnt + {31'd0, r_sync};
      o_duty_valid <= 1'b0;
      if (w_timeout) begin
        o_signal_lost   <= 1'b1;
        o_duty_valid    <= 1'b1;
        o_duty_value    <= {8{r_sync}};
        o_period_cycles <= '0;
        r_state         <= ST_WAIT_RISE;
      end else begin
        case (r_state)
          ST_WAIT_RISE: if (w_rise) begin
            o_signal_lost <= 1'b0;
            r_state       <= ST_MEASURE;
          end
          ST_MEASURE: if (w_rise && r_period_cnt >= c_min_period) begin
            r_p     <= r_period_cnt;
            r_h     <= r_high_cnt;
            r_bit   <= 4'd9;
            r_state <= ST_DIVIDE;
          end
          // r_bit==9 marks the numerator cycle; 8..0 are the quotient bits.
          ST_DIVIDE: if (r_bit == 4'd9) begin
            r_rem <= w_num;
            r_q   <= '0;
            r_bit <= 4'd8;
          end else begin
            if (w_ge) r_rem <= r_rem - w_div;
            r_q[r_bit] <= w_ge;
            if (r_bit == 4'd0) begin
              o_duty_value    <= w_q[8] ? 8'hFF : w_q[7:0];
              o_period_cycles <= r_p;
              o_duty_valid    <= 1'b1;
              r_state         <= ST_OUTPUT;
            end else begin
              r_bit <= r_bit - 4'd1;
            end
          end
          default: r_state <= ST_MEASURE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_led_pwm_duty_decoder.sv
// tb_led_pwm_duty_decoder: directed PWM patterns with hand-computed decode results.
module tb_led_pwm_duty_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm = 1'b0;
  logic [7:0]  duty;
  logic        valid;
  logic [31:0] per;
  logic        lost;
  int          cyc = 0, npulse = 0, lcyc = 0, tot = 0, bad = 0;
  logic [7:0]  lval = '0;
  logic [31:0] lper = '0;
  int          r, base;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid) begin
    npulse <= npulse + 1;
    lval   <= duty;
    lper   <= per;
    lcyc   <= cyc;
  end
  led_pwm_duty_decoder #(
    .parm_FCLK(1_000_000),
    .parm_pwm_period_milliseconds(1),
    .parm_timeout_periods(2),
    .parm_min_period_cycles(16)
  ) dut (
    .i_clk(clk),
    .i_srst(rst),
    .ei_pwm(pwm),
    .o_duty_value(duty),
    .o_duty_valid(valid),
    .o_period_cycles(per),
    .o_signal_lost(lost)
  );
  task automatic chk(input string tag, input longint got, input longint exp);
    tot++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // One PWM period starting with a rising drive; t is the cycle of that drive.
  // The decoded pulse for the previous period lands at t+13 (2 sync + 11).
  task automatic run(input int p, input int h, output int t);
    pwm = 1'b1;
    t = cyc;
    step(h);
    pwm = 1'b0;
    step(p - h);
  endtask
  initial begin
    step(3);
    chk("rst_duty", duty, 0);
    chk("rst_valid", valid, 0);
    chk("rst_per", per, 0);
    chk("rst_lost", lost, 0);
    rst = 1'b0;
    step(5);
    base = npulse;
    run(1000, 500, r);
    chk("first_edge_no_pulse", npulse, base);
    run(1000, 500, r);
    chk("h500_cnt", npulse, base + 1);
    chk("h500_val", lval, 128);
    chk("h500_per", lper, 1000);
    chk("h500_lat", lcyc, r + 13);
    run(1000, 500, r);
    chk("h500b_val", lval, 128);
    chk("h500b_lat", lcyc, r + 13);
    run(1000, 999, r);
    chk("h500c_val", lval, 128);
    run(1000, 1, r);
    chk("h999_val", lval, 255);
    chk("h999_per", lper, 1000);
    run(100, 25, r);
    chk("h1_val", lval, 0);
    chk("h1_per", lper, 1000);
    chk("h1_lat", lcyc, r + 13);
    run(100, 25, r);
    chk("p100h25_val", lval, 64);
    chk("p100h25_per", lper, 100);
    run(100, 75, r);
    chk("p100h25b_val", lval, 64);
    run(100, 75, r);
    chk("p100h75_val", lval, 191);
    chk("p100h75_lat", lcyc, r + 13);
    run(100, 60, r);
    chk("p100h75b_val", lval, 191);
    base = npulse;
    run(13, 6, r);
    run(10, 5, r);
    run(100, 50, r);
    chk("glitch_cnt", npulse, base + 1);
    chk("glitch_prev_val", lval, 153);
    run(100, 50, r);
    chk("post_glitch_cnt", npulse, base + 2);
    chk("post_glitch_val", lval, 128);
    chk("post_glitch_per", lper, 100);
    chk("post_glitch_lat", lcyc, r + 13);
    base = npulse;
    pwm = 1'b1;
    r = cyc;
    step(20);
    chk("to_pre_val", lval, 128);
    step(1980);
    chk("to_not_yet", lost, 0);
    step(100);
    chk("to_lost", lost, 1);
    chk("to_cnt", npulse, base + 2);
    chk("to_val", lval, 255);
    chk("to_per", lper, 0);
    chk("to_time", lcyc, r + 2003);
    step(300);
    chk("to_single", npulse, base + 2);
    pwm = 1'b0;
    step(50);
    chk("to_lost_hold", lost, 1);
    base = npulse;
    run(100, 50, r);
    chk("resume_lost_clr", lost, 0);
    chk("resume_no_pulse", npulse, base);
    run(100, 50, r);
    chk("resume_cnt", npulse, base + 1);
    chk("resume_val", lval, 128);
    run(100, 50, r);
    chk("pre_rst_val", lval, 128);
    base = npulse;
    pwm = 1'b1;
    r = cyc;
    step(7);
    rst = 1'b1;
    pwm = 1'b0;
    step(2);
    rst = 1'b0;
    step(30);
    chk("rst_abort_cnt", npulse, base);
    chk("rst_abort_duty", duty, 0);
    chk("rst_abort_per", per, 0);
    chk("rst_abort_lost", lost, 0);
    run(100, 50, r);
    chk("rst_wait_rise", npulse, base);
    run(100, 50, r);
    chk("rst_recover_cnt", npulse, base + 1);
    chk("rst_recover_val", lval, 128);
    chk("rst_recover_lat", lcyc, r + 13);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
